// File: rtl/audio_spdif_tx.sv
// S/PDIF transmitter: sample FIFO feeding a 64-cell biphase-mark subframe encoder (B/M/W preambles).
// Latency: line updates one clk after each cell tick; backpressure: tready low whenever the FIFO is full.

module sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module audio_spdif_tx #(
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cfg_enable_i,
  input  logic [DIV_W-1:0]            cfg_div_i,
  input  logic [31:0]                 cfg_chstat_i,
  input  logic                        inport_tvalid_i,
  input  logic [31:0]                 inport_tdata_i,
  output logic                        inport_tready_o,
  output logic                        spdif_o,
  output logic                        underrun_o,
  output logic                        block_start_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  logic                fifo_push;
  logic                fifo_pop;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                unused_tdata;

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [5:0]          cell_cnt;
  logic                sf_r;
  logic [7:0]          frame_cnt;

  logic                sf_start;
  logic                block_start;
  logic                underrun;
  logic [31:0]         chstat_q;
  logic [31:0]         chstat_eff;
  logic [23:0]         aud_new;
  logic [23:0]         aud_sel;
  logic                v_bit;
  logic                c_bit;
  logic                p_bit;
  logic [27:0]         sf_word;
  logic                inv_q;
  logic                inv_now;
  logic [7:0]          pat;
  logic [4:0]          slot_idx;
  logic                slot_bit;
  logic                spdif_q;
  logic                spdif_d;
  logic                underrun_q;
  logic                block_start_q;

  // Upper word bits carry no sample data.
  assign unused_tdata = ^inport_tdata_i[31:SAMPLE_W];

  assign inport_tready_o = !rst_i && !fifo_full;
  assign fifo_push       = inport_tvalid_i && inport_tready_o;

  sync_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .din   (inport_tdata_i[SAMPLE_W-1:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .level (fifo_level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Divider idles at zero so the first enabled cycle is always a tick.
  assign tick = cfg_enable_i && (div_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_enable_i) div_cnt <= '0;
    else if (tick)              div_cnt <= cfg_div_i;
    else                        div_cnt <= div_cnt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_enable_i) begin
      cell_cnt  <= '0;
      sf_r      <= 1'b0;
      frame_cnt <= '0;
    end else if (tick) begin
      cell_cnt <= cell_cnt + 1'b1;
      if (cell_cnt == 6'd63) begin
        sf_r <= ~sf_r;
        if (sf_r) frame_cnt <= (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 1'b1;
      end
    end
  end

  assign sf_start    = tick && (cell_cnt == 6'd0);
  assign block_start = sf_start && !sf_r && (frame_cnt == 8'd0);
  assign underrun    = sf_start && fifo_empty;
  assign fifo_pop    = sf_start && !fifo_empty;

  // Channel status is latched at the B preamble; frame 0 uses the live value.
  assign chstat_eff = block_start ? cfg_chstat_i : chstat_q;
  assign aud_new    = 24'(fifo_dout) << (24 - SAMPLE_W);
  assign aud_sel    = fifo_empty ? 24'd0 : aud_new;
  assign v_bit      = fifo_empty;
  assign c_bit      = (frame_cnt < 8'd32) ? chstat_eff[frame_cnt[4:0]] : 1'b0;
  assign p_bit      = ^{aud_sel, v_bit, c_bit};

  assign pat      = sf_r ? PRE_W : ((frame_cnt == 8'd0) ? PRE_B : PRE_M);
  assign inv_now  = sf_start ? spdif_q : inv_q;
  assign slot_idx = cell_cnt[5:1] - 5'd4;
  assign slot_bit = sf_word[slot_idx];

  always_comb begin
    spdif_d = spdif_q;
    if (!cfg_enable_i) begin
      spdif_d = 1'b0;
    end else if (tick) begin
      if (cell_cnt < 6'd8)   spdif_d = pat[3'd7 - cell_cnt[2:0]] ^ inv_now;
      else if (!cell_cnt[0]) spdif_d = ~spdif_q;
      else if (slot_bit)     spdif_d = ~spdif_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spdif_q       <= 1'b0;
      underrun_q    <= 1'b0;
      block_start_q <= 1'b0;
      inv_q         <= 1'b0;
      chstat_q      <= '0;
      sf_word       <= '0;
    end else begin
      spdif_q       <= spdif_d;
      underrun_q    <= underrun;
      block_start_q <= block_start;
      if (sf_start) begin
        inv_q   <= spdif_q;
        sf_word <= {p_bit, c_bit, 1'b0, v_bit, aud_sel};
      end
      if (block_start) chstat_q <= cfg_chstat_i;
    end
  end

  assign spdif_o       = spdif_q;
  assign underrun_o    = underrun_q;
  assign block_start_o = block_start_q;
endmodule

// File: tb/tb_audio_spdif_tx.sv
// Scoreboard bench: two transmitters (24- and 16-bit samples) share stimulus; a monitor
// captures every line cell and compares whole subframes with a slot-level reference model.
module tb_audio_spdif_tx;
  localparam int DEPTH = 8;
  localparam int DIV_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, tvalid;
  logic [DIV_W-1:0] div;
  logic [31:0]      chstat, tdata;
  logic             rdy24, rdy16, sp24, sp16, ur24, ur16, bs24, bs16;
  logic [3:0]       lv24, lv16;

  audio_spdif_tx #(.SAMPLE_W(24), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) u_dut24 (
    .clk_i(clk), .rst_i(rst), .cfg_enable_i(en), .cfg_div_i(div), .cfg_chstat_i(chstat),
    .inport_tvalid_i(tvalid), .inport_tdata_i(tdata), .inport_tready_o(rdy24),
    .spdif_o(sp24), .underrun_o(ur24), .block_start_o(bs24), .fifo_level_o(lv24));

  audio_spdif_tx #(.SAMPLE_W(16), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .cfg_enable_i(en), .cfg_div_i(div), .cfg_chstat_i(chstat),
    .inport_tvalid_i(tvalid), .inport_tdata_i(tdata), .inport_tready_o(rdy16),
    .spdif_o(sp16), .underrun_o(ur16), .block_start_o(bs16), .fifo_level_o(lv16));

  typedef struct {
    logic [63:0] c24;
    logic [63:0] c16;
    bit          urun;
    bit          bstart;
    int          level;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mfifo[$];
  int          sf_g = 0;
  bit          lvl24 = 1'b0, lvl16 = 1'b0;
  int          n_chk = 0, n_fail = 0;
  event        mon_start;
  bit          mon_busy = 1'b0;
  int          mon_n, mon_div;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line cells for one subframe, built from slot meanings; level carries across subframes.
  function automatic logic [63:0] encode(input logic [7:0] pat, input logic [23:0] aud,
                                         input bit v, input bit c, input bit lvl_in,
                                         output bit lvl_out);
    logic [63:0] cells;
    bit l, b;
    for (int j = 0; j < 8; j++) cells[j] = pat[7-j] ^ lvl_in;
    l = cells[7];
    for (int s = 4; s < 32; s++) begin
      if (s < 28)       b = aud[s-4];
      else if (s == 28) b = v;
      else if (s == 29) b = 1'b0;
      else if (s == 30) b = c;
      else              b = (^aud) ^ v ^ c;
      l = ~l;
      cells[2*s] = l;
      if (b) l = ~l;
      cells[2*s+1] = l;
    end
    lvl_out = l;
    return cells;
  endfunction

  task automatic queue_sf(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t        e;
      int          frame;
      bit          r, v, c;
      logic [7:0]  pat;
      logic [31:0] w;
      logic [23:0] a24, a16;
      frame = (sf_g / 2) % 192;
      r     = (sf_g % 2) == 1;
      pat   = r ? 8'b11100100 : ((frame == 0) ? 8'b11101000 : 8'b11100010);
      if (mfifo.size() > 0) begin
        w = mfifo.pop_front();
        a24 = w[23:0]; a16 = {w[15:0], 8'h00}; v = 1'b0; e.urun = 1'b0;
      end else begin
        a24 = '0; a16 = '0; v = 1'b1; e.urun = 1'b1;
      end
      c        = (frame < 32) ? chstat[frame] : 1'b0;
      e.c24    = encode(pat, a24, v, c, lvl24, lvl24);
      e.c16    = encode(pat, a16, v, c, lvl16, lvl16);
      e.bstart = !r && (frame == 0);
      e.level  = mfifo.size();
      exp_q.push_back(e);
      sf_g++;
    end
  endtask

  // Monitor: first cell appears after the first tick edge following the start event.
  initial begin
    logic [63:0] a24, a16;
    bit          u24, u16, b24, b16;
    int          l24, l16, extra;
    exp_t        e;
    forever begin
      @(mon_start);
      mon_busy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < mon_n; s++) begin
        extra = 0;
        for (int k = 0; k < 64; k++) begin
          a24[k] = sp24;
          a16[k] = sp16;
          if (k == 0) begin
            u24 = ur24; u16 = ur16; b24 = bs24; b16 = bs16; l24 = int'(lv24); l16 = int'(lv16);
          end else begin
            extra += int'(ur24) + int'(ur16) + int'(bs24) + int'(bs16);
          end
          if (!(s == mon_n - 1 && k == 63)) repeat (mon_div + 1) @(negedge clk);
        end
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_empty: got subframe with no expectation (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("cells24", a24, e.c24);
          chk("cells16", a16, e.c16);
          chk("underrun24", u24, e.urun);
          chk("underrun16", u16, e.urun);
          chk("block_start24", b24, e.bstart);
          chk("block_start16", b16, e.bstart);
          chk("level24", l24, e.level);
          chk("level16", l16, e.level);
          chk("pulse_quiet", extra, 0);
        end
      end
      mon_busy = 1'b0;
    end
  end

  task automatic push_word(input logic [31:0] w);
    bit acc, want;
    acc  = 1'b0;
    want = mfifo.size() < DEPTH;
    tvalid = 1'b1;
    tdata  = w;
    for (int t = 0; t < 3 && !acc; t++) begin
      if (rdy24) acc = 1'b1;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    chk("push_accept", acc, want);
    if (acc) mfifo.push_back(w);
  endtask

  task automatic wait_monitor();
    for (int t = 0; t < 200 && mon_busy; t++) @(posedge clk);
    chk("monitor_done", mon_busy, 0);
  endtask

  // Called just after an edge where transmission becomes active; ends disabled.
  task automatic run_enabled(input int n);
    int cyc;
    mon_n   = n;
    mon_div = int'(div);
    queue_sf(n);
    -> mon_start;
    cyc = n * 64 * (int'(div) + 1);
    repeat (cyc) @(posedge clk);
    #1;
    en = 1'b0;
    wait_monitor();
    @(negedge clk);
    chk("idle_line24", sp24, 0);
    chk("idle_line16", sp16, 0);
    chk("idle_level", lv24, mfifo.size());
    lvl24 = 1'b0; lvl16 = 1'b0; sf_g = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = '0; chstat = '0; tvalid = 1'b0; tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spdif", sp24, 0);
    chk("rst_tready", rdy24, 0);
    chk("rst_tready16", rdy16, 0);
    chk("rst_level", lv24, 0);
    chk("rst_underrun", ur24, 0);
    chk("rst_block_start", bs24, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", rdy24, 1);
    @(posedge clk); #1;

    // Single-bit extremes at half-rate cells
    div = 12'd1;
    push_word(32'h0000_0001);
    push_word(32'h0080_0000);
    en = 1'b1;
    run_enabled(2);

    // Short sample MSB alignment
    div = 12'd0;
    push_word(32'h0000_1234);
    en = 1'b1;
    run_enabled(2);

    // Fill past capacity while disabled, then drain
    for (int i = 0; i < DEPTH + 2; i++) push_word($urandom);
    chk("full_level", lv24, DEPTH);
    chk("full_tready", rdy24, 0);
    en = 1'b1;
    run_enabled(DEPTH + 2);

    // Random data, divider and channel status
    div = 12'($urandom_range(0, 3));
    chstat = $urandom;
    for (int i = 0; i < 5; i++) push_word($urandom);
    en = 1'b1;
    run_enabled(6);

    // Full block of underruns with sparse channel status
    div = 12'd0;
    chstat = 32'h0000_0005;
    en = 1'b1;
    run_enabled(385);

    // Reset hitting cell 30 of the first R subframe
    chstat = $urandom;
    for (int i = 0; i < 4; i++) push_word($urandom);
    en = 1'b1;
    mon_n = 1;
    mon_div = 0;
    queue_sf(1);
    -> mon_start;
    repeat (94) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_spdif", sp24, 0);
    chk("midrst_underrun", ur24, 0);
    chk("midrst_block_start", bs24, 0);
    chk("midrst_level", lv24, 0);
    chk("midrst_level16", lv16, 0);
    chk("midrst_tready", rdy24, 0);
    wait_monitor();
    mfifo.delete();
    lvl24 = 1'b0; lvl16 = 1'b0; sf_g = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_enabled(2);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
